// File: rtl/axis_mc_accumulator_if.sv
// Bundle carrying the sample stream into the accumulator and the result stream out of it.
// The slave view belongs to the accumulator, the master view to the surrounding environment.
interface axis_mc_accumulator_if #(
   parameter int WIDTH       = 3,
   parameter int NO_OF_STEPS = 10,
   parameter int N_CH        = 2
);
   localparam int W_SUM = WIDTH + $clog2(NO_OF_STEPS);
   localparam int W_CNT = $clog2(NO_OF_STEPS + 1);

   logic                             s_valid;
   logic                             s_ready;
   logic [N_CH-1:0][WIDTH-1:0]       s_data;
   logic                             s_last;
   logic                             m_valid;
   logic                             m_ready;
   logic [N_CH-1:0][W_SUM-1:0]       m_data;
   logic [W_CNT-1:0]                 m_count;
   logic                             m_last;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_count, m_last
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_count, m_last
   );
endinterface

// File: rtl/axis_mc_accumulator.sv
// Multi-channel frame accumulator: sums N_CH lanes over up to NO_OF_STEPS beats per frame
// and emits one registered result beat per frame with full output backpressure.
module axis_mc_accumulator #(
   parameter int WIDTH       = 3,
   parameter int NO_OF_STEPS = 10,
   parameter int N_CH        = 2,
   parameter int SIGNED      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   axis_mc_accumulator_if.slave   bus
);
   localparam int W_SUM = WIDTH + $clog2(NO_OF_STEPS);
   localparam int W_CNT = $clog2(NO_OF_STEPS + 1);
   localparam logic [W_CNT-1:0] LAST_IDX = W_CNT'(NO_OF_STEPS - 1);

   logic [W_CNT-1:0]              count_reg;
   logic [N_CH-1:0][W_SUM-1:0]    sum_reg;
   logic [N_CH-1:0][W_SUM-1:0]    ext_data;
   logic [N_CH-1:0][W_SUM-1:0]    sum_next;
   logic [N_CH-1:0][W_SUM-1:0]    m_data_reg;
   logic [W_CNT-1:0]              m_count_reg;
   logic                          m_valid_reg;
   logic                          m_last_reg;
   logic                          s_ready_int;
   logic                          s_fire;
   logic                          end_beat;

   // A held result blocks input, so a closing beat can never overwrite an unread sum.
   assign s_ready_int = !m_valid_reg || bus.m_ready;
   assign s_fire      = bus.s_valid && s_ready_int;
   assign end_beat    = (count_reg == LAST_IDX) || bus.s_last;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
         if (SIGNED != 0) begin : g_sext
            assign ext_data[gi] = {{(W_SUM-WIDTH){bus.s_data[gi][WIDTH-1]}}, bus.s_data[gi]};
         end else begin : g_zext
            assign ext_data[gi] = {{(W_SUM-WIDTH){1'b0}}, bus.s_data[gi]};
         end
         assign sum_next[gi] = (count_reg == '0) ? ext_data[gi] : sum_reg[gi] + ext_data[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg   <= '0;
         sum_reg     <= '0;
         m_data_reg  <= '0;
         m_count_reg <= '0;
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
      end else begin
         if (m_valid_reg && bus.m_ready) begin
            m_valid_reg <= 1'b0;
         end
         // A new result loaded in the same cycle as a drain keeps m_valid high.
         if (s_fire) begin
            sum_reg <= sum_next;
            if (end_beat) begin
               m_data_reg  <= sum_next;
               m_count_reg <= count_reg + W_CNT'(1);
               m_valid_reg <= 1'b1;
               m_last_reg  <= 1'b1;
               count_reg   <= '0;
            end else begin
               count_reg <= count_reg + W_CNT'(1);
            end
         end
      end
   end

   assign bus.s_ready = s_ready_int;
   assign bus.m_valid = m_valid_reg;
   assign bus.m_data  = m_data_reg;
   assign bus.m_count = m_count_reg;
   assign bus.m_last  = m_last_reg;
endmodule

// File: tb/tb_axis_mc_accumulator.sv
// Bench for axis_mc_accumulator: table of frames checked through a result scoreboard,
// plus hand-written sequences for backpressure, reset and signed arithmetic.
module tb_axis_mc_accumulator;
   localparam int W  = 3;
   localparam int NS = 10;
   localparam int C  = 2;
   localparam int WS = 7;
   localparam int WC = 4;

   typedef struct {
      int n;
      int base0;
      int step0;
      int val1;
      bit last;
      int gap;
      int exp0;
      int exp1;
   } vec_t;

   typedef struct {
      logic [C-1:0][WS-1:0] data;
      logic [WC-1:0]        cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   vec_t vecs[8];

   axis_mc_accumulator_if #(.WIDTH(W), .NO_OF_STEPS(NS), .N_CH(C)) bus0 ();
   axis_mc_accumulator_if #(.WIDTH(W), .NO_OF_STEPS(NS), .N_CH(C)) bus1 ();

   axis_mc_accumulator #(.WIDTH(W), .NO_OF_STEPS(NS), .N_CH(C), .SIGNED(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   axis_mc_accumulator #(.WIDTH(W), .NO_OF_STEPS(NS), .N_CH(C), .SIGNED(1)) u_dut_signed (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit v, input int d0, input int d1, input bit last);
      if (sel) begin
         bus1.s_valid   = v;
         bus1.s_data[0] = W'(d0);
         bus1.s_data[1] = W'(d1);
         bus1.s_last    = last;
      end else begin
         bus0.s_valid   = v;
         bus0.s_data[0] = W'(d0);
         bus0.s_data[1] = W'(d1);
         bus0.s_last    = last;
      end
   endtask

   // Presents a beat and returns after the edge that accepted it; waits = stalled cycles.
   task automatic send_beat(input bit sel, input int d0, input int d1, input bit last,
                            output int waits);
      bit rdy;
      waits = 0;
      drive(sel, 1'b1, d0, d1, last);
      forever begin
         @(negedge clk);
         rdy = sel ? bus1.s_ready : bus0.s_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         waits++;
         if (waits > 100) begin
            chk("send_beat_timeout", waits, 0);
            break;
         end
      end
   endtask

   task automatic idle(input bit sel, input int cycles);
      drive(sel, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input int d0, input int d1, input int cnt);
      exp_t e;
      e.data[0] = WS'(d0);
      e.data[1] = WS'(d1);
      e.cnt     = WC'(cnt);
      sb_q.push_back(e);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("scoreboard_drain", sb_q.size(), 0);
   endtask

   // Output monitor: every accepted result is checked against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus0.m_valid && bus0.m_ready) begin
            $display("out: ch0=%0d ch1=%0d count=%0d last=%0d",
                     bus0.m_data[0], bus0.m_data[1], bus0.m_count, bus0.m_last);
            if (sb_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("m_data_ch0", int'(bus0.m_data[0]), int'(e.data[0]));
               chk("m_data_ch1", int'(bus0.m_data[1]), int'(e.data[1]));
               chk("m_count", int'(bus0.m_count), int'(e.cnt));
               chk("m_last", int'(bus0.m_last), 1);
            end
         end
      end
   end

   initial begin
      int waits;
      int stalls;
      // Lane 0 of frames 1 and 2 follows beat index 0..19 modulo 8 (3-bit lanes).
      vecs[0] = '{10, 7, 0, 1, 1'b0, 0, 70, 10};
      vecs[1] = '{10, 0, 1, 0, 1'b0, 0, 29, 0};
      vecs[2] = '{10, 10, 1, 5, 1'b0, 0, 33, 50};
      vecs[3] = '{3, 2, 1, 6, 1'b1, 0, 9, 18};
      vecs[4] = '{10, 1, 0, 7, 1'b0, 2, 10, 70};
      vecs[5] = '{10, 3, 0, 2, 1'b1, 0, 30, 20};
      vecs[6] = '{1, 5, 0, 3, 1'b1, 0, 5, 3};
      vecs[7] = '{2, 7, 0, 7, 1'b1, 0, 14, 14};

      drive(1'b0, 1'b0, 0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      bus0.m_ready = 1'b1;
      bus1.m_ready = 1'b1;
      #2;
      chk("reset_m_valid", int'(bus0.m_valid), 0);
      chk("reset_m_data", int'(bus0.m_data), 0);
      chk("reset_m_count", int'(bus0.m_count), 0);
      chk("reset_m_last", int'(bus0.m_last), 0);
      chk("reset_s_ready", int'(bus0.s_ready), 1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Table frames, sent back to back with m_ready held high.
      stalls = 0;
      foreach (vecs[vi]) begin
         push_exp(vecs[vi].exp0, vecs[vi].exp1, vecs[vi].n);
         $display("in: frame %0d beats=%0d last=%0d gap=%0d", vi, vecs[vi].n,
                  vecs[vi].last, vecs[vi].gap);
         for (int i = 0; i < vecs[vi].n; i++) begin
            send_beat(1'b0, (vecs[vi].base0 + vecs[vi].step0 * i) & 7, vecs[vi].val1,
                      vecs[vi].last && (i == vecs[vi].n - 1), waits);
            stalls += waits;
            if (vecs[vi].gap > 0) idle(1'b0, vecs[vi].gap);
         end
      end
      chk("table_stall_cycles", stalls, 0);
      idle(1'b0, 1);
      wait_drain();

      // Backpressure: result held while m_ready is low, then drained.
      bus0.m_ready = 1'b0;
      push_exp(40, 10, 10);
      $display("in: backpressure frame 1");
      for (int i = 0; i < 10; i++) send_beat(1'b0, 4, 1, 1'b0, waits);
      drive(1'b0, 1'b1, 2, 2, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_m_valid", int'(bus0.m_valid), 1);
         chk("bp_s_ready", int'(bus0.s_ready), 0);
         chk("bp_data_ch0", int'(bus0.m_data[0]), 40);
         chk("bp_data_ch1", int'(bus0.m_data[1]), 10);
         chk("bp_count", int'(bus0.m_count), 10);
         @(posedge clk);
         #1;
      end
      bus0.m_ready = 1'b1;
      push_exp(20, 20, 10);
      $display("in: backpressure frame 2");
      stalls = 0;
      for (int i = 0; i < 10; i++) begin
         send_beat(1'b0, 2, 2, 1'b0, waits);
         stalls += waits;
      end
      chk("bp_frame2_stalls", stalls, 0);
      idle(1'b0, 1);
      wait_drain();

      // Reset mid-frame: partial sum of 4 beats must be discarded.
      $display("in: reset after 4 beats");
      for (int i = 0; i < 4; i++) send_beat(1'b0, 1, 1, 1'b0, waits);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_mid_m_valid", int'(bus0.m_valid), 0);
      chk("rst_mid_m_data", int'(bus0.m_data), 0);
      chk("rst_mid_m_count", int'(bus0.m_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_exp(10, 10, 10);
      for (int i = 0; i < 10; i++) send_beat(1'b0, 1, 1, 1'b0, waits);
      idle(1'b0, 1);
      wait_drain();

      // Reset drops a pending, unaccepted result.
      $display("in: reset with pending result");
      bus0.m_ready = 1'b0;
      send_beat(1'b0, 3, 3, 1'b1, waits);
      drive(1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("pending_m_valid", int'(bus0.m_valid), 1);
      chk("pending_m_count", int'(bus0.m_count), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_pending_m_valid", int'(bus0.m_valid), 0);
      chk("rst_pending_m_data", int'(bus0.m_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus0.m_ready = 1'b1;

      // Signed lanes: 10 x (-4) and 10 x (+3).
      $display("in: signed frame");
      for (int i = 0; i < 10; i++) send_beat(1'b1, 4, 3, 1'b0, waits);
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("signed_m_valid", int'(bus1.m_valid), 1);
      chk("signed_ch0", int'(bus1.m_data[0]), 'h58);
      chk("signed_ch1", int'(bus1.m_data[1]), 30);
      chk("signed_count", int'(bus1.m_count), 10);
      $display("out: signed ch0=%0d ch1=%0d count=%0d", bus1.m_data[0], bus1.m_data[1],
               bus1.m_count);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("signed_drained", int'(bus1.m_valid), 0);

      idle(1'b0, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
